bcd_display_scan: RTL and testbench

Time-multiplexed seven-segment driver that consumes the packed digits of a cascaded BCD counter chain and scans them onto a common-anode display, one digit at a time. It is the reading end of the BCD counter chain. It latches a coherent snapshot of all digits once per scan frame, so a carry ripple never tears the display. It also decodes each digit to segments, blanks leading zeros on request, and shows a dash for non-BCD codes.

---
 rtl/bcd_display_scan.sv | 113 +++++++++++
 tb/tb_bcd_display_scan.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Scans a snapshot of a packed BCD digit chain onto a common-anode seven-segment
// display, one digit per slot, with leading-zero blanking and a dash for non-BCD codes.
module bcd_display_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         count_q, count_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  running_q, running_d;
    logic [4*DIGITS-1:0]   snap_bcd_q, snap_bcd_d;
    logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  tick;
    logic [3:0]            digit;
    logic [6:0]            seg_dec;
    logic                  upper_zero;

    always_comb begin
        tick      = (count_q == CW'(DIV - 1));
        count_d   = tick ? '0 : count_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        running_d = running_q | tick;

        // A new frame starts whenever the scan returns to digit 0; only then is the chain sampled.
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        if (tick && idx_d == '0) begin
            snap_bcd_d = bcd_in;
            snap_dp_d  = dp_in;
        end

        digit = snap_bcd_d[{idx_d, 2'b00} +: 4];
        case (digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase

        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_d) && snap_bcd_d[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end

        // Outputs are built from the next-state values so they line up with count/idx/snapshot.
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (running_d) begin
            seg_d = (blank_lz && idx_d != '0 && upper_zero) ? 7'h7F : seg_dec;
            dp_d  = ~snap_dp_d[idx_d];
            if (int'(count_d) >= BLANK) begin
                an_d = ~(DIGITS'(1) << idx_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            idx_q      <= IW'(DIGITS - 1);
            running_q  <= 1'b0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            count_q    <= count_d;
            idx_q      <= idx_d;
            running_q  <= running_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with DIGITS=4, DIV=8, BLANK=2; edge numbers
// below count clock edges after reset release.
module tb_bcd_display_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests_run = 0;
    int fail_count = 0;

    bcd_display_scan #(.DIGITS(4), .DIV(8), .BLANK(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n active edges, then sample 1 time unit later.
    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] b, input logic [3:0] d, input logic lz);
        bcd_in   = b;
        dp_in    = d;
        blank_lz = lz;
    endtask

    // Called at a frame-start sample point; checks all four slots and ends at the next frame start.
    task automatic checkFrame(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_dp);
        logic [3:0] exp_an;
        for (int d = 0; d < 4; d++) begin
            checkOutput($sformatf("%s seg d%0d", tag, d), {25'd0, seg}, {25'd0, exp_seg[d*7 +: 7]});
            checkOutput($sformatf("%s dp d%0d", tag, d), {31'd0, dp}, {31'd0, exp_dp[d]});
            checkOutput($sformatf("%s an off d%0d", tag, d), {28'd0, an}, 32'hF);
            stepEdges(2);
            exp_an = 4'hF;
            exp_an[d] = 1'b0;
            checkOutput($sformatf("%s an on d%0d", tag, d), {28'd0, an}, {28'd0, exp_an});
            stepEdges(6);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(16'h1234, 4'b0000, 1'b0);
        stepEdges(3);
        checkOutput("reset an", {28'd0, an}, 32'hF);
        checkOutput("reset seg", {25'd0, seg}, 32'h7F);
        checkOutput("reset dp", {31'd0, dp}, 32'h1);

        reset = 1'b0;
        stepEdges(7);
        checkOutput("edge7 an", {28'd0, an}, 32'hF);
        checkOutput("edge7 seg", {25'd0, seg}, 32'h7F);
        checkOutput("edge7 dp", {31'd0, dp}, 32'h1);
        stepEdges(1);
        checkOutput("edge8 seg", {25'd0, seg}, 32'h19);
        checkOutput("edge8 an", {28'd0, an}, 32'hF);
        stepEdges(1);
        checkOutput("edge9 an", {28'd0, an}, 32'hF);
        stepEdges(1);
        checkOutput("edge10 an", {28'd0, an}, 32'hE);
        stepEdges(6);
        checkOutput("edge16 seg", {25'd0, seg}, 32'h30);
        checkOutput("edge16 an", {28'd0, an}, 32'hF);
        stepEdges(2);
        checkOutput("edge18 an", {28'd0, an}, 32'hD);
        stepEdges(2);
        bcd_in = 16'h5678;
        stepEdges(4);
        checkOutput("edge24 seg", {25'd0, seg}, 32'h24);
        stepEdges(2);
        checkOutput("edge26 an", {28'd0, an}, 32'hB);
        stepEdges(6);
        checkOutput("edge32 seg", {25'd0, seg}, 32'h79);
        stepEdges(2);
        checkOutput("edge34 an", {28'd0, an}, 32'h7);
        stepEdges(6);
        checkFrame("coherent 5678", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111);

        applyStimulus(16'h0005, 4'b0000, 1'b1);
        stepEdges(32);
        checkFrame("lz 0005", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111);

        applyStimulus(16'h0000, 4'b0000, 1'b1);
        stepEdges(32);
        checkFrame("lz 0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);

        applyStimulus(16'h0105, 4'b0000, 1'b1);
        stepEdges(32);
        checkFrame("lz 0105", {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b1111);

        applyStimulus(16'h00A9, 4'b0000, 1'b1);
        stepEdges(32);
        checkFrame("invalid 00A9", {7'h7F, 7'h7F, 7'h3F, 7'h10}, 4'b1111);

        applyStimulus(16'h1234, 4'b0100, 1'b0);
        stepEdges(32);
        checkFrame("dp 0100", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011);

        stepEdges(19);
        checkOutput("mid d2 an", {28'd0, an}, 32'hB);
        checkOutput("mid d2 dp", {31'd0, dp}, 32'h0);
        reset = 1'b1;
        stepEdges(1);
        checkOutput("midreset an", {28'd0, an}, 32'hF);
        checkOutput("midreset seg", {25'd0, seg}, 32'h7F);
        checkOutput("midreset dp", {31'd0, dp}, 32'h1);
        reset = 1'b0;
        stepEdges(7);
        checkOutput("restart edge7 an", {28'd0, an}, 32'hF);
        checkOutput("restart edge7 seg", {25'd0, seg}, 32'h7F);
        stepEdges(1);
        checkFrame("restart", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
